frame_buf_pp: RTL and testbench

- Parametrised single-clock ping-pong frame buffer; successor to the dual-clock 24-bit frame buffer.
- Two banks of FRAME_PIXELS words each. The writer fills one bank while the reader drains the other, and the banks swap on frame boundaries.
- Adds back-pressure (ready), overflow/underflow flags, a registered read-valid and frame-done pulses.
- Sits between the pixel source (camera/decoder) and the display/stream consumer.

---
 rtl/frame_buf_pp.sv | 129 ++++++++++++
 tb/tb_frame_buf_pp.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/frame_buf_pp.sv
// Single-clock ping-pong frame buffer with back-pressure, sticky overflow/underflow
// and frame-done pulses. Define FRAME_BUF_REPEAT_EN to repeat the last frame when starved.
module frame_buf_pp #(
  parameter int unsigned DATA_WIDTH   = 24,
  parameter int unsigned FRAME_PIXELS = 16,
  parameter int unsigned ADDR_WIDTH   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_en_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  rd_valid,
  output logic                  wr_ready,
  output logic                  rd_ready,
  output logic                  wr_bank,
  output logic                  rd_bank,
  output logic                  wr_frame_done,
  output logic                  rd_frame_done,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(FRAME_PIXELS - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] r_mem [2][FRAME_PIXELS];

  logic [1:0]            r_full;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [ADDR_WIDTH-1:0] r_rd_addr;
  logic                  r_wr_bank;
  logic                  r_rd_bank;
  logic [DATA_WIDTH-1:0] r_data_out;
  logic                  r_rd_valid;
  logic                  r_wr_frame_done;
  logic                  r_rd_frame_done;
  logic                  r_overflow;
  logic                  r_underflow;

  logic                  w_wr_ready;
  logic                  w_rd_ready;
  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic                  w_wr_last;
  logic                  w_rd_last;
  logic                  w_rd_release;
  logic [1:0]            w_full_d;

  assign w_wr_ready = ~r_full[r_wr_bank];
  assign w_rd_ready = r_full[r_rd_bank];
  assign w_wr_acc   = ~wr_en_in & w_wr_ready;
  assign w_rd_acc   = ~rd_en_in & w_rd_ready;
  assign w_wr_last  = (r_wr_addr == ADDR_LAST);
  assign w_rd_last  = (r_rd_addr == ADDR_LAST);

`ifdef FRAME_BUF_REPEAT_EN
  // Keep the current frame unless the other bank already holds a complete one.
  assign w_rd_release = r_full[~r_rd_bank];
`else
  assign w_rd_release = 1'b1;
`endif

  // Write and read accepts always target different banks, so both updates compose.
  always_comb begin
    w_full_d = r_full;
    if (w_wr_acc && w_wr_last) w_full_d[r_wr_bank] = 1'b1;
    if (w_rd_acc && w_rd_last && w_rd_release) w_full_d[r_rd_bank] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (w_wr_acc) r_mem[r_wr_bank][r_wr_addr] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_full          <= 2'b00;
      r_wr_addr       <= '0;
      r_rd_addr       <= '0;
      r_wr_bank       <= 1'b0;
      r_rd_bank       <= 1'b0;
      r_data_out      <= '0;
      r_rd_valid      <= 1'b0;
      r_wr_frame_done <= 1'b0;
      r_rd_frame_done <= 1'b0;
      r_overflow      <= 1'b0;
      r_underflow     <= 1'b0;
    end else begin
      r_full          <= w_full_d;
      r_rd_valid      <= w_rd_acc;
      r_wr_frame_done <= w_wr_acc & w_wr_last;
      r_rd_frame_done <= w_rd_acc & w_rd_last;
      if (~wr_en_in & ~w_wr_ready) r_overflow <= 1'b1;
      if (~rd_en_in & ~w_rd_ready) r_underflow <= 1'b1;

      if (w_wr_acc) begin
        if (w_wr_last) begin
          r_wr_addr <= '0;
          r_wr_bank <= ~r_wr_bank;
        end else begin
          r_wr_addr <= r_wr_addr + ADDR_ONE;
        end
      end

      if (w_rd_acc) begin
        r_data_out <= r_mem[r_rd_bank][r_rd_addr];
        if (w_rd_last) begin
          r_rd_addr <= '0;
          if (w_rd_release) r_rd_bank <= ~r_rd_bank;
        end else begin
          r_rd_addr <= r_rd_addr + ADDR_ONE;
        end
      end
    end
  end

  assign data_out      = r_data_out;
  assign rd_valid      = r_rd_valid;
  assign wr_ready      = w_wr_ready;
  assign rd_ready      = w_rd_ready;
  assign wr_bank       = r_wr_bank;
  assign rd_bank       = r_rd_bank;
  assign wr_frame_done = r_wr_frame_done;
  assign rd_frame_done = r_rd_frame_done;
  assign overflow      = r_overflow;
  assign underflow     = r_underflow;

endmodule

// File: tb/tb_frame_buf_pp.sv
// Scoreboard bench for frame_buf_pp (FRAME_PIXELS=4): expected pixels are queued at
// read issue and a negedge monitor pops/compares whenever rd_valid is high.
module tb_frame_buf_pp;

  localparam int unsigned DW = 24;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_en_in;
  logic [DW-1:0] data_in;
  logic          rd_en_in;
  logic [DW-1:0] data_out;
  logic          rd_valid, wr_ready, rd_ready, wr_bank, rd_bank;
  logic          wr_frame_done, rd_frame_done, overflow, underflow;

  int n_tests = 0;
  int n_fail  = 0;
  logic [DW-1:0] exp_q[$];

  frame_buf_pp #(
    .DATA_WIDTH  (DW),
    .FRAME_PIXELS(4),
    .ADDR_WIDTH  (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_en_in     (wr_en_in),
    .data_in      (data_in),
    .rd_en_in     (rd_en_in),
    .data_out     (data_out),
    .rd_valid     (rd_valid),
    .wr_ready     (wr_ready),
    .rd_ready     (rd_ready),
    .wr_bank      (wr_bank),
    .rd_bank      (rd_bank),
    .wr_frame_done(wr_frame_done),
    .rd_frame_done(rd_frame_done),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every valid read pixel must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rd_valid === 1'b1) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL rd_unexpected: got %h expected none", data_out);
      end else begin
        logic [DW-1:0] e;
        e = exp_q.pop_front();
        if (data_out !== e) begin
          n_fail++;
          $display("FAIL rd_data: got %h expected %h", data_out, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b0;
    repeat (cycles) tick();
    reset = 1'b1;
  endtask

  task automatic write_px(input logic [DW-1:0] d);
    wr_en_in = 1'b0;
    data_in  = d;
    tick();
    wr_en_in = 1'b1;
  endtask

  // push=1 when the read is expected to be accepted.
  task automatic read_px(input logic [DW-1:0] e, input bit push);
    if (push) exp_q.push_back(e);
    rd_en_in = 1'b0;
    tick();
    rd_en_in = 1'b1;
  endtask

  initial begin
    reset    = 1'b0;
    wr_en_in = 1'b1;
    rd_en_in = 1'b1;
    data_in  = '0;

    // 1: reset state, underflow on empty read
    do_reset(2);
    check("rst_data_out", data_out, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_wr_ready", wr_ready, 1);
    check("rst_rd_ready", rd_ready, 0);
    check("rst_banks", {wr_bank, rd_bank}, 0);
    check("rst_flags", {overflow, underflow}, 0);
    read_px(0, 0);
    check("t1_underflow", underflow, 1);
    check("t1_rd_valid", rd_valid, 0);
    check("t1_data_out", data_out, 0);

    // 2: one frame in, one frame out
    for (int i = 1; i <= 3; i++) write_px(DW'(i));
    check("t2_wfd_early", wr_frame_done, 0);
    write_px(4);
    check("t2_wr_frame_done", wr_frame_done, 1);
    check("t2_rd_ready", rd_ready, 1);
    check("t2_wr_bank", wr_bank, 1);
    for (int i = 1; i <= 4; i++) read_px(DW'(i), 1);
    check("t2_rd_frame_done", rd_frame_done, 1);
    check("t2_rd_ready_after", rd_ready, 0);
    check("t2_rd_bank", rd_bank, 1);
    tick();
    check("t2_rfd_pulse_end", rd_frame_done, 0);

    // 3: both banks full, overflow drop
    do_reset(1);
    for (int i = 1; i <= 8; i++) write_px(DW'(i));
    check("t3_wr_ready", wr_ready, 0);
    check("t3_banks_equal", {wr_bank, rd_bank}, 2'b00);
    check("t3_overflow_pre", overflow, 0);
    write_px('hA);
    check("t3_overflow", overflow, 1);
    for (int i = 1; i <= 8; i++) read_px(DW'(i), 1);
    check("t3_rd_ready_end", rd_ready, 0);
    check("t3_wr_ready_end", wr_ready, 1);

    // 4: concurrent write/read without stalls
    do_reset(1);
    for (int i = 1; i <= 4; i++) write_px(DW'(i));
    for (int i = 0; i < 4; i++) begin
      check("t4_no_stall_w", wr_ready, 1);
      check("t4_no_stall_r", rd_ready, 1);
      exp_q.push_back(DW'(i + 1));
      wr_en_in = 1'b0;
      data_in  = DW'(i + 5);
      rd_en_in = 1'b0;
      tick();
      wr_en_in = 1'b1;
      rd_en_in = 1'b1;
    end
    check("t4_rd_bank", rd_bank, 1);
    check("t4_rd_ready", rd_ready, 1);
    for (int i = 5; i <= 8; i++) read_px(DW'(i), 1);

    // 5: reset discards partial frame
    do_reset(1);
    write_px(1);
    write_px(2);
    do_reset(1);
    check("t5_rd_ready", rd_ready, 0);
    for (int i = 'hB; i <= 'hE; i++) write_px(DW'(i));
    check("t5_rd_bank", rd_bank, 0);
    for (int i = 'hB; i <= 'hE; i++) read_px(DW'(i), 1);

    // 6: starved reader
    do_reset(1);
    for (int i = 1; i <= 4; i++) write_px(DW'(i));
    for (int i = 1; i <= 4; i++) read_px(DW'(i), 1);
`ifdef FRAME_BUF_REPEAT_EN
    for (int i = 1; i <= 4; i++) read_px(DW'(i), 1);
    check("t6_underflow", underflow, 0);
    for (int i = 5; i <= 8; i++) write_px(DW'(i));
    for (int i = 1; i <= 4; i++) read_px(DW'(i), 1);
    check("t6_rd_bank", rd_bank, 1);
    for (int i = 5; i <= 8; i++) read_px(DW'(i), 1);
`else
    check("t6_underflow_pre", underflow, 0);
    read_px(0, 0);
    check("t6_underflow", underflow, 1);
    check("t6_rd_valid", rd_valid, 0);
`endif

    tick();
    tick();
    check("sb_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
